// File: rtl/fa32_mp_seq_if.sv
// Request/response channel bundle for the multi-precision add/subtract sequencer.
interface fa32_mp_seq_if #(
  parameter int WORDS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [WORDS*32-1:0]   req_a;
  logic [WORDS*32-1:0]   req_b;
  logic                  req_sub;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WORDS*32-1:0]   rsp_sum;
  logic                  rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/fa32_mp_seq.sv
// Multi-precision add/subtract sequencer: feeds an external 32-bit adder one word
// per cycle, LSW first, chaining the carry through a register.
module fa32_mp_seq #(
  parameter int WORDS = 4,
  parameter int IW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fa32_mp_seq_if.slave        bus,
  output logic [31:0]         add_a,
  output logic [31:0]         add_b,
  output logic                add_cin,
  input  logic [31:0]         add_sum,
  input  logic                add_cout,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_n;
  logic [IW-1:0]          idx;
  logic                   carry;
  logic [WORDS-1:0][31:0] a_reg;
  logic [WORDS-1:0][31:0] b_reg;
  logic [WORDS-1:0][31:0] sum_reg;
  logic                   cout_reg;
  logic                   last;

  assign last          = (idx == IW'(WORDS - 1));
  assign busy          = (state != IDLE);
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_sum   = sum_reg;
  assign bus.rsp_cout  = cout_reg;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.req_valid) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Word mux into the adder; the adder sees zeros whenever it is not in use.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_cin = carry;
      for (int w = 0; w < WORDS; w++) begin
        if (idx == IW'(w)) begin
          add_a = a_reg[w];
          add_b = b_reg[w];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_reg <= bus.req_a;
            // Subtraction is A + ~B + 1, so invert B once on capture.
            b_reg <= bus.req_sub ? ~bus.req_b : bus.req_b;
            carry <= bus.req_sub;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx == IW'(w)) sum_reg[w] <= add_sum;
          end
          carry <= add_cout;
          if (last) cout_reg <= add_cout;
          else      idx      <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
